// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: registers one op per cycle, aligns/extends loads, and runs sub-word stores as read-modify-write.
// Optional feature: define MEM_STAGE_CHECK_EN to enable misalignment/range fault detection.
module mem_access_stage #(
  parameter int ADDR_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        fault,
  output logic [31:0] mem_read_addr,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] ADDR_WORDS_W = 32'(ADDR_WORDS);

  typedef enum logic {S_RUN, S_RMW} state_e;

  state_e      state_q, state_d;
  logic        s_valid_q, s_valid_d;
  logic        op_load_q, op_load_d;
  logic        op_store_q, op_store_d;
  logic [1:0]  op_size_q, op_size_d;
  logic        op_signed_q, op_signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] merge_q, merge_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        fault_q, fault_d;

  logic        is_byte, is_half;
  logic [31:0] word_idx;
  logic        access_fault;
  logic        stall;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign is_byte = (op_size_q == 2'b00);
  assign is_half = (op_size_q == 2'b01);

`ifdef MEM_STAGE_CHECK_EN
  assign word_idx     = {2'b00, addr_q[31:2]};
  assign access_fault = (op_load_q | op_store_q) &
                        ((is_half & addr_q[0]) |
                         (op_size_q[1] & (addr_q[1:0] != 2'b00)) |
                         (word_idx >= ADDR_WORDS_W));
`else
  // Without checking, out-of-range indices wrap instead of faulting.
  assign word_idx     = {2'b00, addr_q[31:2]} % ADDR_WORDS_W;
  assign access_fault = 1'b0;
`endif

  // Lane selection for loads and lane replacement for the RMW merge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    byte_sel = 8'h00;
    merged   = mem_read_data;
    case (addr_q[1:0])
      2'd0: byte_sel = mem_read_data[7:0];
      2'd1: byte_sel = mem_read_data[15:8];
      2'd2: byte_sel = mem_read_data[23:16];
      2'd3: byte_sel = mem_read_data[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    if (is_byte)      load_data = {{24{op_signed_q & byte_sel[7]}}, byte_sel};
    else if (is_half) load_data = {{16{op_signed_q & half_sel[15]}}, half_sel};
    else              load_data = mem_read_data;

    if (is_byte) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = store_data_q[7:0];
        2'd1: merged[15:8]  = store_data_q[7:0];
        2'd2: merged[23:16] = store_data_q[7:0];
        2'd3: merged[31:24] = store_data_q[7:0];
        default: merged     = mem_read_data;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = store_data_q[15:0];
    end else begin
      merged[15:0]  = store_data_q[15:0];
    end
  end

  // Next-state, memory control and WB result.
  always_comb begin
    state_d          = state_q;
    merge_d          = merge_q;
    stall            = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    wb_valid_d       = 1'b0;
    wb_data_d        = 32'h0;
    wb_rd_d          = 5'd0;
    wb_reg_write_d   = 1'b0;
    fault_d          = 1'b0;

    case (state_q)
      S_RUN: begin
        if (s_valid_q) begin
          wb_rd_d = rd_q;
          if (access_fault) begin
            wb_valid_d = 1'b1;
            fault_d    = 1'b1;
          end else if (op_load_q) begin
            mem_read_enable = 1'b1;
            wb_valid_d      = 1'b1;
            wb_data_d       = load_data;
            wb_reg_write_d  = reg_write_q;
          end else if (op_store_q && op_size_q[1]) begin
            mem_write_enable = 1'b1;
            mem_write_data   = store_data_q;
            wb_valid_d       = 1'b1;
          end else if (op_store_q) begin
            // First half of RMW: capture the merged word, finish next cycle.
            mem_read_enable = 1'b1;
            merge_d         = merged;
            stall           = 1'b1;
            state_d         = S_RMW;
            wb_rd_d         = 5'd0;
          end else begin
            wb_valid_d     = 1'b1;
            wb_data_d      = addr_q;
            wb_reg_write_d = reg_write_q;
          end
        end
      end
      S_RMW: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merge_q;
        wb_valid_d       = 1'b1;
        wb_rd_d          = rd_q;
        state_d          = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Stage register capture; fields hold when nothing is accepted.
  always_comb begin
    s_valid_d    = 1'b0;
    op_load_d    = op_load_q;
    op_store_d   = op_store_q;
    op_size_d    = op_size_q;
    op_signed_d  = op_signed_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    if (in_valid && !stall) begin
      s_valid_d    = 1'b1;
      op_load_d    = op_load;
      op_store_d   = op_store;
      op_size_d    = op_size;
      op_signed_d  = op_signed;
      addr_d       = addr;
      store_data_d = store_data;
      rd_d         = rd_in;
      reg_write_d  = reg_write_in;
    end else if (state_d == S_RMW) begin
      s_valid_d = s_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      s_valid_q      <= 1'b0;
      op_load_q      <= 1'b0;
      op_store_q     <= 1'b0;
      op_size_q      <= 2'b00;
      op_signed_q    <= 1'b0;
      addr_q         <= 32'h0;
      store_data_q   <= 32'h0;
      rd_q           <= 5'd0;
      reg_write_q    <= 1'b0;
      // NOTE: merge_q is a data register, but it is reset so that a reset mid-RMW leaves no stale merged word behind.
      merge_q        <= 32'h0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'h0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      s_valid_q      <= s_valid_d;
      op_load_q      <= op_load_d;
      op_store_q     <= op_store_d;
      op_size_q      <= op_size_d;
      op_signed_q    <= op_signed_d;
      addr_q         <= addr_d;
      store_data_q   <= store_data_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      merge_q        <= merge_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      fault_q        <= fault_d;
    end
  end

  assign in_ready       = rst_n & ~stall;
  assign mem_read_addr  = word_idx;
  assign mem_write_addr = word_idx;
  assign wb_valid       = wb_valid_q;
  assign wb_data        = wb_data_q;
  assign wb_rd          = wb_rd_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a 32-word behavioural data memory.
// Fault checks follow MEM_STAGE_CHECK_EN; the default build checks the wrapping behaviour instead.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_load, op_store;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        fault;
  logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [32];
  logic        mem_load;
  int          we_count = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_load(op_load), .op_store(op_store), .op_size(op_size), .op_signed(op_signed),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fault(fault), .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  // Combinational-read, synchronous-write data memory; word i preloads to i+1.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i + 1);
    end else if (mem_write_enable) begin
      mem[mem_write_addr[4:0]] <= mem_write_data;
    end
    if (mem_write_enable) we_count <= we_count + 1;
  end
  assign mem_read_data = mem[mem_read_addr[4:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic rw);
    op_load = ld; op_store = st; op_size = sz; op_signed = sgn;
    addr = a; store_data = d; rd_in = rd; reg_write_in = rw;
    in_valid = 1'b1;
  endtask

  // Issue one op, then wait (bounded) for its WB result; reports latency and stall cycles.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input logic rw, output int lat, output int stalls,
                        output logic [31:0] data, output logic [4:0] rd_o,
                        output logic regw, output logic flt);
    @(negedge clk);
    drive(ld, st, sz, sgn, a, d, rd, rw);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    stalls = 0;
    while (!wb_valid && lat < 8) begin
      if (!in_ready) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
    data = wb_data;
    rd_o = wb_rd;
    regw = wb_reg_write;
    flt  = fault;
  endtask

  int          lat, stalls, we_base;
  logic [31:0] data, word0;
  logic [4:0]  rd_o;
  logic        regw, flt;

  initial begin
    rst_n = 1'b0;
    mem_load = 1'b1;
    in_valid = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_load = 1'b0;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("rst_mem_addr", mem_read_addr | mem_write_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Word load after reset.
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 5'd3, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw0c_lat", 32'(lat), 32'd1);
    check("lw0c_data", data, 32'h0000_0004);
    check("lw0c_regw", 32'(regw), 32'd1);
    check("lw0c_rd", 32'(rd_o), 32'd3);
    @(posedge clk);
    #1;
    check("lw0c_one_cycle", 32'(wb_valid), 32'd0);

    // Byte store then loads.
    run_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h80, 5'd0, 1'b0, lat, stalls, data, rd_o, regw, flt);
    check("sb_stall", 32'(stalls), 32'd1);
    check("sb_lat", 32'(lat), 32'd2);
    check("sb_regw", 32'(regw), 32'd0);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 5'd4, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lbu09", data, 32'h0000_0080);
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h09, 32'h0, 5'd4, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lb09", data, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 5'd4, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw08", data, 32'h0000_8003);

    // Halfword store then loads.
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hBEEF, 5'd0, 1'b0, lat, stalls, data, rd_o, regw, flt);
    check("sh_stall", 32'(stalls), 32'd1);
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 5'd5, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lh12", data, 32'hFFFF_BEEF);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd5, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lhu12", data, 32'h0000_BEEF);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd5, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw10", data, 32'hBEEF_0005);

    // Pass-through op.
    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 5'd7, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("pass_data", data, 32'h1234_5678);
    check("pass_lat", 32'(lat), 32'd1);
    check("pass_regw", 32'(regw), 32'd1);

`ifdef MEM_STAGE_CHECK_EN
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 5'd6, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw06_fault", 32'(flt), 32'd1);
    check("lw06_data", data, 32'h0);
    check("lw06_regw", 32'(regw), 32'd0);
    we_base = we_count;
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h1122_3344, 5'd0, 1'b0, lat, stalls, data, rd_o, regw, flt);
    check("sw80_fault", 32'(flt), 32'd1);
    check("sw80_no_we", 32'(we_count - we_base), 32'd0);
    word0 = 32'h0000_0001;
`else
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 5'd6, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw06_nofault", 32'(flt), 32'd0);
    check("lw06_data", data, 32'h0000_0002);
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 5'd6, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lhu13_data", data, 32'h0000_BEEF);
    we_base = we_count;
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h1122_3344, 5'd0, 1'b0, lat, stalls, data, rd_o, regw, flt);
    check("sw80_wrap_we", 32'(we_count - we_base), 32'd1);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 5'd6, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw00_wrapped", data, 32'h1122_3344);
    word0 = 32'h1122_3344;
`endif
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 5'd6, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("lw7c_data", data, 32'd32);

    // Store immediately followed by a load of the same word.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hDEAD_BEEF, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    check("swlw_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 5'd9, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("sw04_wb_valid", 32'(wb_valid), 32'd1);
    check("sw04_regw", 32'(wb_reg_write), 32'd0);
    @(posedge clk);
    #1;
    check("lw04_wb_valid", 32'(wb_valid), 32'd1);
    check("lw04_data", wb_data, 32'hDEAD_BEEF);
    check("lw04_rd", 32'(wb_rd), 32'd9);

    // Reset while the RMW write is pending.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h00, 32'h55, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rmw_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rmw_we_pending", 32'(mem_write_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    we_base = we_count;
    check("rmwrst_wb", {wb_valid, wb_reg_write, fault, 29'd0}, 32'h0);
    check("rmwrst_wb_data", wb_data, 32'h0);
    check("rmwrst_wb_rd", 32'(wb_rd), 32'd0);
    check("rmwrst_mem_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("rmwrst_wdata", mem_write_data, 32'h0);
    check("rmwrst_addr", mem_read_addr | mem_write_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmwrst_ready", 32'(in_ready), 32'd1);
    check("rmwrst_no_write", 32'(we_count - we_base), 32'd0);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 5'd2, 1'b1, lat, stalls, data, rd_o, regw, flt);
    check("post_rst_lat", 32'(lat), 32'd1);
    check("post_rst_word0", data, word0);
    check("post_rst_regw", 32'(regw), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
